// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: count modes, directions and a
// width helper for the prescaler phase register.
package counter_pkg;

   localparam int unsigned MODE_WRAP = 0;
   localparam int unsigned MODE_SAT  = 1;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // A phase register always needs at least one bit, even when PRESCALE is 1.
   function automatic int unsigned prescale_width(int unsigned prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable divider: tick is high on every PRESCALE-th enabled cycle; the phase
// holds while enable is low and restarts on reset or clear.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned    PW   = prescale_width(PRESCALE);
   localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] phase_q;
   logic          at_last;

   assign at_last = (phase_q == LAST);
   assign tick    = enable && at_last;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         phase_q <= '0;
      end else if (enable) begin
         phase_q <= at_last ? '0 : phase_q + PW'(1);
      end
   end

endmodule

// File: rtl/updown_counter.sv
// Prescaled up/down counter bounded to 0..MAX_COUNT, wrapping or saturating at
// the bounds, with a one-cycle wrap pulse and a sticky overflow flag.
module updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH     = 4,
   parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
   parameter int unsigned     SATURATE  = MODE_WRAP,
   parameter int unsigned     PRESCALE  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_down,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             clear,
   output logic [WIDTH-1:0] counter_out,
   output logic             terminal_count,
   output logic             wrap,
   output logic             overflow
);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $fatal(1, "updown_counter: WIDTH must be within 2..32");
   end
   if (MAX_COUNT < 1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $fatal(1, "updown_counter: MAX_COUNT must be within 1..2**WIDTH-1");
   end
   if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
      $fatal(1, "updown_counter: SATURATE must be 0 or 1");
   end
   if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
      $fatal(1, "updown_counter: PRESCALE must be within 1..256");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
   localparam logic             SAT     = (SATURATE == MODE_SAT);

   logic [WIDTH-1:0] count_q, stepped, load_clamped;
   logic             wrap_q, overflow_q;
   logic             tick, at_bound;

   // Load restarts the prescale phase just like clear does.
   counter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .clear  (clear || load),
      .enable (enable),
      .tick   (tick)
   );

   always_comb begin
      at_bound     = 1'b0;
      stepped      = count_q;
      load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
      if (up_down == DIR_DOWN) begin
         at_bound = (count_q == '0);
         stepped  = at_bound ? (SAT ? '0 : MAX_VAL) : count_q - WIDTH'(1);
      end else begin
         at_bound = (count_q == MAX_VAL);
         stepped  = at_bound ? (SAT ? MAX_VAL : '0) : count_q + WIDTH'(1);
      end
      terminal_count = tick && at_bound;
   end

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count_q    <= '0;
         wrap_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (load) begin
         count_q <= load_clamped;
         wrap_q  <= 1'b0;
      end else if (tick) begin
         count_q <= stepped;
         wrap_q  <= terminal_count;
         if (terminal_count) begin
            overflow_q <= 1'b1;
         end
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign counter_out = count_q;
   assign wrap        = wrap_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: three counter configurations share random and directed
// stimulus; an arithmetic reference model predicts each one's outputs.
module tb_updown_counter;

   localparam int MAXC = 9;
   localparam int NDUT = 3;

   typedef struct {
      int dut;
      int cnt;
      bit wrp;
      bit ovf;
      bit tc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset, enable, up_down, load, clear;
   logic [3:0] load_value;
   logic [3:0] cnt_o  [NDUT];
   logic       tc_o   [NDUT];
   logic       wrap_o [NDUT];
   logic       ovf_o  [NDUT];

   exp_t sb[$];
   int   m_cnt [NDUT];
   int   m_ph  [NDUT];
   bit   m_ovf [NDUT];
   bit   m_wrp [NDUT];
   bit   known = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clock = ~clock;

   updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .PRESCALE(1)) u_wrap (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(load_value), .clear(clear), .counter_out(cnt_o[0]),
      .terminal_count(tc_o[0]), .wrap(wrap_o[0]), .overflow(ovf_o[0])
   );
   updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1), .PRESCALE(1)) u_sat (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(load_value), .clear(clear), .counter_out(cnt_o[1]),
      .terminal_count(tc_o[1]), .wrap(wrap_o[1]), .overflow(ovf_o[1])
   );
   updown_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0), .PRESCALE(3)) u_pre (
      .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
      .load_value(load_value), .clear(clear), .counter_out(cnt_o[2]),
      .terminal_count(tc_o[2]), .wrap(wrap_o[2]), .overflow(ovf_o[2])
   );

   function automatic int pre_of(int i);
      return (i == 2) ? 3 : 1;
   endfunction

   function automatic bit sat_of(int i);
      return (i == 1);
   endfunction

   // Count after one step: modular arithmetic when wrapping, clamping when saturating.
   function automatic int next_count(int i, int c, bit ud);
      if (sat_of(i)) begin
         if (ud) return (c >= MAXC) ? MAXC : c + 1;
         return (c <= 0) ? 0 : c - 1;
      end
      if (ud) return (c + 1) % (MAXC + 1);
      return (c + MAXC) % (MAXC + 1);
   endfunction

   task automatic check(string name, int dut, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0d expected %0d", name, dut, act, exp);
      end
   endtask

   // Drive one cycle of inputs, record what each DUT should show now, advance the model.
   task automatic cycle(bit rst, bit clr, bit ld, int lv, bit en, bit ud);
      @(negedge clock);
      reset      = rst;
      clear      = clr;
      load       = ld;
      load_value = 4'(lv);
      enable     = en;
      up_down    = ud;
      for (int i = 0; i < NDUT; i++) begin
         bit   tick;
         bit   tc;
         exp_t e;
         tick = en && (m_ph[i] == pre_of(i) - 1);
         tc   = tick && (ud ? (m_cnt[i] == MAXC) : (m_cnt[i] == 0));
         if (known) begin
            e.dut = i;
            e.cnt = m_cnt[i];
            e.wrp = m_wrp[i];
            e.ovf = m_ovf[i];
            e.tc  = tc;
            sb.push_back(e);
         end
         if (rst || clr) begin
            m_cnt[i] = 0;
            m_ph[i]  = 0;
            m_ovf[i] = 1'b0;
            m_wrp[i] = 1'b0;
         end else if (ld) begin
            m_cnt[i] = (lv > MAXC) ? MAXC : lv;
            m_ph[i]  = 0;
            m_wrp[i] = 1'b0;
         end else if (tick) begin
            m_ph[i]  = 0;
            m_wrp[i] = tc;
            m_ovf[i] = m_ovf[i] | tc;
            m_cnt[i] = next_count(i, m_cnt[i], ud);
         end else begin
            if (en) m_ph[i] = m_ph[i] + 1;
            m_wrp[i] = 1'b0;
         end
      end
      if (rst || clr) known = 1'b1;
   endtask

   // Monitor: compare every pending expectation against the live outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front();
            check("counter_out", e.dut, 32'(cnt_o[e.dut]), e.cnt);
            check("wrap", e.dut, 32'(wrap_o[e.dut]), 32'(e.wrp));
            check("overflow", e.dut, 32'(ovf_o[e.dut]), 32'(e.ovf));
            check("terminal_count", e.dut, 32'(tc_o[e.dut]), 32'(e.tc));
         end
      end
   end

   initial begin
      reset = 1'b1; clear = 1'b0; load = 1'b0; load_value = '0;
      enable = 1'b0; up_down = 1'b1;

      repeat (2) cycle(1, 0, 0, 0, 0, 1);

      // Count up through the wrap point.
      repeat (12) cycle(0, 0, 0, 0, 1, 1);
      @(posedge clock); #1;
      check("up12_count", 0, 32'(cnt_o[0]), 2);
      check("up12_overflow", 0, 32'(ovf_o[0]), 1);
      check("up12_sat_count", 1, 32'(cnt_o[1]), 9);
      check("up12_pre_count", 2, 32'(cnt_o[2]), 4);

      // Load 0 and count down across the lower bound.
      cycle(0, 0, 1, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 0, 1, 0);
      @(posedge clock); #1;
      check("down2_count", 0, 32'(cnt_o[0]), 8);

      // Saturation at the top bound.
      cycle(0, 0, 1, 8, 0, 1);
      repeat (4) cycle(0, 0, 0, 0, 1, 1);
      @(posedge clock); #1;
      check("sat_count", 1, 32'(cnt_o[1]), 9);
      check("sat_wrap", 1, 32'(wrap_o[1]), 1);

      // Prescale phase from reset, then held while enable is low.
      cycle(1, 0, 0, 0, 0, 1);
      repeat (9) cycle(0, 0, 0, 0, 1, 1);
      @(posedge clock); #1;
      check("pre9_count", 2, 32'(cnt_o[2]), 3);
      cycle(0, 0, 0, 0, 1, 1);
      repeat (2) cycle(0, 0, 0, 0, 0, 1);
      repeat (4) cycle(0, 0, 0, 0, 1, 1);

      // Clamped load, and a load beating a step at the bound.
      cycle(0, 0, 1, 15, 0, 1);
      @(posedge clock); #1;
      check("clamp_count", 0, 32'(cnt_o[0]), 9);
      cycle(0, 0, 1, 9, 1, 1);
      @(posedge clock); #1;
      check("load_wins_wrap", 0, 32'(wrap_o[0]), 0);

      // Reset with overflow set, then clear together with load.
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 1, 5, 0, 1);
      cycle(1, 0, 0, 0, 0, 1);
      @(posedge clock); #1;
      check("reset_count", 0, 32'(cnt_o[0]), 0);
      check("reset_overflow", 0, 32'(ovf_o[0]), 0);
      cycle(0, 0, 1, 6, 0, 1);
      cycle(0, 1, 1, 7, 1, 1);
      @(posedge clock); #1;
      check("clear_load_count", 0, 32'(cnt_o[0]), 0);

      repeat (500) begin
         cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3),
               ($urandom_range(0, 99) < 6), int'($urandom_range(0, 15)),
               ($urandom_range(0, 99) < 75), 1'($urandom));
      end

      repeat (2) cycle(0, 0, 0, 0, 0, 1);
      @(negedge clock); #2;
      check("scoreboard_drained", 0, 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (2..32).
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1, highest count value; legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap at the bounds, 1 = hold at the bounds.
REQ-004 SHALL have parameter PRESCALE, default 1; number of enabled cycles per count step (1..256).
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  input  1  count enable.
REQ-008 SHALL have port up_down  input  1  direction; 1 = up, 0 = down.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_value  input  WIDTH  value taken on load.
REQ-011 SHALL have port clear  input  1  synchronous clear of the count, the prescaler and the overflow flag.
REQ-012 SHALL have port counter_out  output  WIDTH  registered count.
REQ-013 SHALL have port terminal_count  output  1  combinational; high when the next step would cross a bound.
REQ-014 SHALL have port wrap  output  1  registered one-cycle pulse when the count wrapped or saturated.
REQ-015 SHALL have port overflow  output  1  sticky flag for any wrap or saturation event.

Function
REQ-016 SHALL apply per-cycle priority: reset > clear > load > enable step > hold.
REQ-017 SHALL define a step as: enable high and the prescaler reaching PRESCALE-1; the prescaler then returns to 0, otherwise it increments while enable is high; with PRESCALE=1 every enabled cycle is a step.
REQ-018 SHALL hold the prescaler value while enable is low, and SHALL zero it on load, clear or reset.
REQ-019 SHALL move counter_out by +1 (up) or -1 (down) on each step, with the result in range 0..MAX_COUNT.
REQ-020 SHALL, with SATURATE=0, go from MAX_COUNT to 0 when stepping up and from 0 to MAX_COUNT when stepping down.
REQ-021 SHALL, with SATURATE=1, hold MAX_COUNT when stepping up and hold 0 when stepping down at the bound.
REQ-022 SHALL drive terminal_count = enable AND prescaler at PRESCALE-1 AND ((up_down AND counter_out==MAX_COUNT) OR (!up_down AND counter_out==0)).
REQ-023 SHALL assert wrap for exactly the one cycle after a step taken with terminal_count high, in both modes.
REQ-024 SHALL set overflow on the same edge that wrap rises, and hold it until clear or reset.
REQ-025 SHALL clamp load_value above MAX_COUNT to MAX_COUNT on load, and SHALL not assert wrap or overflow for a load.
REQ-026 SHALL let load win over a same-cycle step, so a load at a bound produces no wrap.
REQ-027 SHALL have up_down changes take effect on the next step, with no extra latency.

Reset
REQ-028 SHALL, on reset high at a rising clock edge, set counter_out=0, prescaler=0, wrap=0 and overflow=0; terminal_count then follows REQ-022.
REQ-029 SHALL let reset mid-count or mid-prescale abandon the step in progress; after reset deasserts, the first step needs a full PRESCALE enabled cycles.
REQ-030 SHALL have no asynchronous paths; reset is sampled only on clock.

Structure
REQ-031 SHALL place the mode constants (MODE_WRAP=0, MODE_SAT=1) and the direction constants (DIR_UP=1, DIR_DOWN=0) in shared package counter_pkg.
REQ-032 SHALL implement the prescaler as sub-module counter_prescaler (ports clock, reset, clear, enable, tick), parameterised by PRESCALE.
REQ-033 SHALL reject illegal parameter combinations at elaboration.

Verification
REQ-034 SHALL cover: WIDTH=4, MAX_COUNT=9, SATURATE=0, PRESCALE=1, reset, then enable up for 12 cycles -> counter_out 1..9,0,1,2; wrap high for one cycle after 9->0; overflow=1 from then on.
REQ-035 SHALL cover: same configuration, load 0, down, 2 steps -> counter_out 9 then 8; terminal_count high while counter_out=0 and enable=1.
REQ-036 SHALL cover: SATURATE=1, MAX_COUNT=9, load 8, up for 4 steps -> counter_out 9,9,9,9; wrap pulses once per step attempted at 9; overflow=1.
REQ-037 SHALL cover: PRESCALE=3, enable high for 9 cycles -> counter_out 0,0,1,1,1,2,2,2,3; enable dropped for 2 cycles mid-prescale -> prescaler phase held.
REQ-038 SHALL cover: load_value=15 with MAX_COUNT=9 -> counter_out=9, no wrap; load and step together at 9 -> load wins, wrap stays 0.
REQ-039 SHALL cover: reset asserted at counter_out=5 with overflow=1 -> next cycle counter_out=0, overflow=0, wrap=0; clear and load together -> counter_out=0.
